fft_stream_reader: RTL and testbench



---
 rtl/fft_stream_reader_if.sv | 30 +++
 rtl/fft_stream_reader.sv | 164 ++++++++++++++++
 tb/tb_fft_stream_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_reader_if.sv
// Bank-read and TX stream signals of fft_stream_reader.
// master = the reader (drives reads and the stream), slave = memories + consumer.
interface fft_stream_reader_if #(
  parameter int unsigned R  = 5,
  parameter int unsigned DW = 16
);
  logic            o_m0_r_en;
  logic [R-2:0]    o_m0_addr;
  logic [2*DW-1:0] i_m0_rdata;
  logic            o_m1_r_en;
  logic [R-2:0]    o_m1_addr;
  logic [2*DW-1:0] i_m1_rdata;
  logic [2*DW-1:0] o_tx_data;
  logic            o_tx_valid;
  logic            i_tx_ready;
  logic            o_tx_last;
  logic [R-1:0]    o_tx_idx;

  modport master (
    output o_m0_r_en, o_m0_addr, o_m1_r_en, o_m1_addr,
    output o_tx_data, o_tx_valid, o_tx_last, o_tx_idx,
    input  i_m0_rdata, i_m1_rdata, i_tx_ready
  );

  modport slave (
    input  o_m0_r_en, o_m0_addr, o_m1_r_en, o_m1_addr,
    input  o_tx_data, o_tx_valid, o_tx_last, o_tx_idx,
    output i_m0_rdata, i_m1_rdata, i_tx_ready
  );
endinterface

// File: rtl/fft_stream_reader.sv
// Streams one N-point FFT frame from two ping-pong banks onto a valid/ready stream.
// Optional stall counter output enabled by FFT_STREAM_STALL_CNT_EN.
module fft_stream_reader #(
  parameter int unsigned N      = 32,
  parameter int unsigned R      = 5,
  parameter int unsigned DW     = 16,
  parameter int unsigned BITREV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
`ifdef FFT_STREAM_STALL_CNT_EN
  output logic [15:0] o_stall_cnt,
`endif
  fft_stream_reader_if.master io_bus
);

  localparam int unsigned SW = 2 * DW;
  localparam int unsigned AW = R - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [SW-1:0] data;
    logic [R-1:0]  idx;
    logic          last;
  } entry_t;

  function automatic logic [R-1:0] f_bitrev(input logic [R-1:0] x);
    logic [R-1:0] y;
    for (int i = 0; i < int'(R); i++) y[i] = x[R-1-i];
    return y;
  endfunction

  state_t        r_state, w_state_nxt;
  logic          r_busy, r_done;
  logic [R-1:0]  r_c;
  logic          r_infl, r_infl_bank, r_infl_last;
  logic [R-1:0]  r_infl_idx;
  logic [AW-1:0] r_m0_addr, r_m1_addr;
  entry_t        r_e0, r_e1;
  logic [1:0]    r_count;
  logic          r_valid;

  logic [R-1:0]  w_m;
  logic          w_bank;
  logic [AW-1:0] w_addr;
  logic          w_pop, w_push, w_issue, w_accept, w_last_read;
  logic [1:0]    w_committed, w_count_nxt, w_slot;
  entry_t        w_new;

  // Memory index for the current sequence count; bank is the parity of the index.
  assign w_m    = (BITREV != 0) ? f_bitrev(r_c) : r_c;
  assign w_bank = ^w_m;
  assign w_addr = w_m[AW-1:0];

  // Credit: FIFO entries plus the in-flight read never exceed the 2 FIFO slots.
  assign w_pop       = r_valid & io_bus.i_tx_ready;
  assign w_push      = r_infl;
  assign w_committed = r_count + 2'(r_infl);
  assign w_issue     = (r_state == S_RUN) && ((w_committed - 2'(w_pop)) < 2'd2);
  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_last_read = w_issue && (r_c == R'(N - 1));
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
  assign w_slot      = r_count - 2'(w_pop);

  assign w_new.data = r_infl_bank ? io_bus.i_m1_rdata : io_bus.i_m0_rdata;
  assign w_new.idx  = r_infl_idx;
  assign w_new.last = r_infl_last;

  // Read port: the idle bank keeps presenting its last address.
  assign io_bus.o_m0_r_en = w_issue & ~w_bank;
  assign io_bus.o_m1_r_en = w_issue &  w_bank;
  assign io_bus.o_m0_addr = (w_issue & ~w_bank) ? w_addr : r_m0_addr;
  assign io_bus.o_m1_addr = (w_issue &  w_bank) ? w_addr : r_m1_addr;

  assign io_bus.o_tx_data  = r_e0.data;
  assign io_bus.o_tx_idx   = r_e0.idx;
  assign io_bus.o_tx_last  = r_e0.last;
  assign io_bus.o_tx_valid = r_valid;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // DRAIN finishes on the cycle that empties the FIFO, so o_done follows the last pop directly.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_read) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((w_count_nxt == 2'd0) && !r_infl) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c         <= '0;
      r_infl      <= 1'b0;
      r_infl_bank <= 1'b0;
      r_infl_idx  <= '0;
      r_infl_last <= 1'b0;
      r_m0_addr   <= '0;
      r_m1_addr   <= '0;
    end else begin
      if (w_accept)     r_c <= '0;
      else if (w_issue) r_c <= r_c + R'(1);
      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_bank <= w_bank;
        r_infl_idx  <= r_c;
        r_infl_last <= (r_c == R'(N - 1));
      end
      if (w_issue & ~w_bank) r_m0_addr <= w_addr;
      if (w_issue &  w_bank) r_m1_addr <= w_addr;
    end
  end

  // Two-entry shift FIFO: entry 0 is always the head, so stream outputs come straight from flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != 2'd0);
      if (w_pop) r_e0 <= r_e1;
      if (w_push) begin
        if (w_slot == 2'd0) r_e0 <= w_new;
        else                r_e1 <= w_new;
      end
    end
  end

`ifdef FFT_STREAM_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept)
      r_stall_cnt <= '0;
    else if (r_valid && !io_bus.i_tx_ready && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fft_stream_reader.sv
// Bench for fft_stream_reader: N=8 instances with BITREV=1 (dut 0) and BITREV=0 (dut 1) in lockstep.
module tb_fft_stream_reader;
  localparam int unsigned N  = 8;
  localparam int unsigned R  = 3;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst, start, ready;
  logic busy_a, done_a, busy_b, done_b;
`ifdef FFT_STREAM_STALL_CNT_EN
  logic [15:0] stall_a, stall_b;
`endif

  fft_stream_reader_if #(.R(R), .DW(DW)) ifa ();
  fft_stream_reader_if #(.R(R), .DW(DW)) ifb ();

  fft_stream_reader #(.N(N), .R(R), .DW(DW), .BITREV(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy_a), .o_done(done_a),
`ifdef FFT_STREAM_STALL_CNT_EN
    .o_stall_cnt(stall_a),
`endif
    .io_bus(ifa.master));

  fft_stream_reader #(.N(N), .R(R), .DW(DW), .BITREV(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy_b), .o_done(done_b),
`ifdef FFT_STREAM_STALL_CNT_EN
    .o_stall_cnt(stall_b),
`endif
    .io_bus(ifb.master));

  always #5 clk = ~clk;

  assign ifa.i_tx_ready = ready;
  assign ifb.i_tx_ready = ready;

  // Logical contents: index m lives in bank parity(m), address m[1:0].
  logic [31:0] la [N];
  logic [31:0] mem_a0 [4], mem_a1 [4], mem_b0 [4], mem_b1 [4];
  logic [2:0]  seq_a [N] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd5, 3'd1, 3'd3, 3'd7};
  logic [2:0]  seq_b [N] = '{3'd0, 3'd5, 3'd6, 3'd3, 3'd4, 3'd1, 3'd2, 3'd7};

  // One-cycle read latency; junk on the bus when not reading.
  always @(posedge clk) begin
    ifa.i_m0_rdata <= ifa.o_m0_r_en ? mem_a0[ifa.o_m0_addr] : 32'($urandom);
    ifa.i_m1_rdata <= ifa.o_m1_r_en ? mem_a1[ifa.o_m1_addr] : 32'($urandom);
    ifb.i_m0_rdata <= ifb.o_m0_r_en ? mem_b0[ifb.o_m0_addr] : 32'($urandom);
    ifb.i_m1_rdata <= ifb.o_m1_r_en ? mem_b1[ifb.o_m1_addr] : 32'($urandom);
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int stall_seen = 0;
  int exp_idx [2], pops [2], reads [2], done_cnt [2], first_valid [2], last_pop_cyc [2];
  logic        prev_stall [2];
  logic [31:0] prev_data [2];
  logic [2:0]  prev_idx [2];
  logic        prev_last [2];
  logic [2:0]  log0 [$];
  logic [2:0]  log1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected sample for output index k: natural order reads location bitreverse(k).
  function automatic logic [31:0] exp_data(input int d, input int k);
    int m = 0;
    if (d == 0) begin
      for (int i = 0; i < 3; i++) if ((k >> i) & 1) m += 4 >> i;
      return la[m];
    end
    return 32'(k);
  endfunction

  task automatic observe(input int d, input logic v, input logic last, input logic [2:0] idx,
                         input logic [31:0] data, input logic r0, input logic r1,
                         input logic [1:0] a0, input logic [1:0] a1, input logic done);
    string s;
    s = $sformatf("[%0d]", d);
    chk({"ren_onehot", s}, 32'(r0 & r1), 32'd0);
    if (r0 | r1) begin
      reads[d]++;
      if (d == 0) log0.push_back({r1, r1 ? a1 : a0});
      else        log1.push_back({r1, r1 ? a1 : a0});
    end
    if (prev_stall[d]) begin
      chk({"stall_valid", s}, 32'(v), 32'd1);
      chk({"stall_data", s}, data, prev_data[d]);
      chk({"stall_idx", s}, 32'(idx), 32'(prev_idx[d]));
      chk({"stall_last", s}, 32'(last), 32'(prev_last[d]));
    end
    if (v && first_valid[d] < 0) first_valid[d] = cyc;
    if (v && ready) begin
      chk({"idx", s}, 32'(idx), 32'(exp_idx[d]));
      chk({"data", s}, data, exp_data(d, exp_idx[d]));
      chk({"last", s}, 32'(last), 32'(exp_idx[d] == N - 1));
      if (exp_idx[d] == N - 1) last_pop_cyc[d] = cyc;
      exp_idx[d]++;
      pops[d]++;
    end
    chk({"credit", s}, 32'(reads[d] - pops[d] <= 2), 32'd1);
    if (done) begin
      done_cnt[d]++;
      chk({"done_lat", s}, 32'(cyc - last_pop_cyc[d]), 32'd1);
    end
    prev_stall[d] = v & ~ready & ~rst;
    prev_data[d]  = data;
    prev_idx[d]   = idx;
    prev_last[d]  = last;
  endtask

  // Inputs are set at posedge+1; outputs observed at posedge+3, before the next edge.
  task automatic step();
    #2;
    observe(0, ifa.o_tx_valid, ifa.o_tx_last, ifa.o_tx_idx, ifa.o_tx_data,
            ifa.o_m0_r_en, ifa.o_m1_r_en, ifa.o_m0_addr, ifa.o_m1_addr, done_a);
    observe(1, ifb.o_tx_valid, ifb.o_tx_last, ifb.o_tx_idx, ifb.o_tx_data,
            ifb.o_m0_r_en, ifb.o_m1_r_en, ifb.o_m0_addr, ifb.o_m1_addr, done_b);
    if (ifa.o_tx_valid && !ready) stall_seen++;
    if (start && !busy_a && !rst) start_cyc = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_init();
    for (int d = 0; d < 2; d++) begin
      exp_idx[d] = 0; pops[d] = 0; reads[d] = 0; done_cnt[d] = 0;
      first_valid[d] = -1; last_pop_cyc[d] = -100;
    end
    log0.delete();
    log1.delete();
    stall_seen = 0;
  endtask

  task automatic run_frame(input bit rnd, input bit noisy, input bit tail);
    frame_init();
    start = 1'b1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 300 && done_cnt[0] == 0; i++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (noisy && busy_a && !done_a) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    chk("frame_done_seen", 32'(done_cnt[0] != 0), 32'd1);
    start = 1'b0;
    ready = 1'b1;
    if (tail) begin
      repeat (3) step();
      chk("busy_after", 32'({busy_a, busy_b}), 32'd0);
      chk("done_once[0]", 32'(done_cnt[0]), 32'd1);
      chk("done_once[1]", 32'(done_cnt[1]), 32'd1);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("samples[%0d]", d), 32'(exp_idx[d]), 32'(N));
      chk($sformatf("reads[%0d]", d), 32'(reads[d]), 32'(N));
      chk($sformatf("latency[%0d]", d), 32'(first_valid[d] - start_cyc), 32'd3);
    end
    for (int i = 0; i < int'(N); i++) begin
      chk($sformatf("rdseq_a%0d", i), (i < log0.size()) ? 32'(log0[i]) : 32'hDEAD, 32'(seq_a[i]));
      chk($sformatf("rdseq_b%0d", i), (i < log1.size()) ? 32'(log1[i]) : 32'hDEAD, 32'(seq_b[i]));
    end
`ifdef FFT_STREAM_STALL_CNT_EN
    chk("stall_cnt_a", 32'(stall_a), 32'(stall_seen));
    chk("stall_cnt_b", 32'(stall_b), 32'(stall_seen));
`endif
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'({ifa.o_tx_valid, ifb.o_tx_valid}), 32'd0);
    chk({tag, "_busy"}, 32'({busy_a, busy_b}), 32'd0);
    chk({tag, "_done"}, 32'({done_a, done_b}), 32'd0);
    chk({tag, "_ren"}, 32'({ifa.o_m0_r_en, ifa.o_m1_r_en, ifb.o_m0_r_en, ifb.o_m1_r_en}), 32'd0);
  endtask

  initial begin
    for (int m = 0; m < int'(N); m++) begin
      la[m] = $urandom;
      if (^(3'(m))) begin mem_a1[m % 4] = la[m]; mem_b1[m % 4] = 32'(m); end
      else          begin mem_a0[m % 4] = la[m]; mem_b0[m % 4] = 32'(m); end
    end
    for (int d = 0; d < 2; d++) prev_stall[d] = 1'b0;
    frame_init();
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) step();
    chk_quiet("reset");
    chk("reset_data", ifa.o_tx_data | ifb.o_tx_data, 32'd0);
    chk("reset_idx", 32'({ifa.o_tx_idx, ifb.o_tx_idx}), 32'd0);
    chk("reset_last", 32'({ifa.o_tx_last, ifb.o_tx_last}), 32'd0);
    chk("reset_addr", 32'({ifa.o_m0_addr, ifa.o_m1_addr, ifb.o_m0_addr, ifb.o_m1_addr}), 32'd0);
    rst = 1'b0;
    step();

    // Full-rate frame, then a second frame started the cycle after o_done.
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);

    // Random backpressure with stray i_start pulses during RUN/DRAIN.
    run_frame(1'b1, 1'b1, 1'b1);
    run_frame(1'b1, 1'b1, 1'b1);

    // Reset while sample 3 is at the head and the FIFO is full.
    frame_init();
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50 && pops[0] < 3; i++) step();
    ready = 1'b0;
    repeat (3) step();
    chk("pre_rst_full", 32'(reads[0] - pops[0]), 32'd2);
    chk("pre_rst_head", 32'(ifa.o_tx_idx), 32'd3);
    chk("pre_rst_valid", 32'(ifa.o_tx_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready = 1'b1;
    chk_quiet("post_rst");
    run_frame(1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
